// File: rtl/group_shift_pkg.sv
// Shared constants and types for the group shift block.
package group_shift_pkg;
  localparam int GROUP_CNT     = 8;
  localparam int GROUP_BITS    = 64;
  localparam int ITEM_GRPS_MAX = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} shiftState_t;

  // A dense mask is a run of ones reaching the top group; any 1 followed by a 0 above it is a hole.
  function automatic logic mask_holes(input logic [GROUP_CNT-1:0] m);
    return |(m[GROUP_CNT-2:0] & ~m[GROUP_CNT-1:1]);
  endfunction
endpackage

// File: rtl/group_shift_step.sv
// Combinational one-group move of every masked group: up (insert) or down (delete),
// with the vacated end slot taken from fill_i.
module group_shift_step
  import group_shift_pkg::*;
(
  input  logic [GROUP_CNT*GROUP_BITS-1:0] row_i,
  input  logic [GROUP_CNT-1:0]            mask_i,
  input  logic                            del_i,
  input  logic [GROUP_BITS-1:0]           fill_i,
  output logic [GROUP_CNT*GROUP_BITS-1:0] row_o
);
  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_grp
    logic [GROUP_BITS-1:0] up_src, dn_src;
    if (g == 0) begin : g_bot
      assign up_src = fill_i;
    end else begin : g_mid_up
      assign up_src = mask_i[g-1] ? row_i[(g-1)*GROUP_BITS +: GROUP_BITS] : fill_i;
    end
    if (g == GROUP_CNT-1) begin : g_top
      assign dn_src = fill_i;
    end else begin : g_mid_dn
      assign dn_src = row_i[(g+1)*GROUP_BITS +: GROUP_BITS];
    end
    assign row_o[g*GROUP_BITS +: GROUP_BITS] = !mask_i[g] ? row_i[g*GROUP_BITS +: GROUP_BITS]
                                             : (del_i ? dn_src : up_src);
  end
endmodule

// File: rtl/group_shift.sv
// Shifts masked row groups up (insert) or down (delete) by one item, one group per cycle.
// Optional dense-mask check: define GROUP_SHIFT_MASK_CHECK_EN.
module group_shift
  import group_shift_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                go,
  input  logic                                delOp,
  input  logic                                inxBit,
  input  logic [GROUP_CNT-1:0]                grpMask,
  input  logic [GROUP_CNT*GROUP_BITS-1:0]     rowIn,
  input  logic [ITEM_GRPS_MAX*GROUP_BITS-1:0] newItem,
  input  logic [ITEM_GRPS_MAX*GROUP_BITS-1:0] carryIn,
  output logic [GROUP_CNT*GROUP_BITS-1:0]     rowOut,
  output logic [ITEM_GRPS_MAX*GROUP_BITS-1:0] carryOut,
  output logic                                carryValid,
  output logic                                busy,
  output logic                                done,
  output logic                                maskErr
);
  shiftState_t                         state_q, state_d;
  logic [GROUP_CNT*GROUP_BITS-1:0]     row_q, row_d, row_step;
  logic [GROUP_CNT-1:0]                mask_q, mask_d;
  logic                                del_q, del_d;
  logic [1:0]                          k_q, k_d, s_q, s_d, slot;
  logic [ITEM_GRPS_MAX*GROUP_BITS-1:0] carry_q, carry_d;
  logic                                cv_q, cv_d;
  logic [GROUP_BITS-1:0]               fill;
`ifdef GROUP_SHIFT_MASK_CHECK_EN
  logic                                merr_q, merr_d;
`endif

  // Insert consumes the item top-down so the lowest item group is placed last.
  assign slot = k_q - 2'd1 - s_q;
  assign fill = del_q ? carryIn[s_q*GROUP_BITS +: GROUP_BITS]
                      : newItem[slot*GROUP_BITS +: GROUP_BITS];

  group_shift_step u_step (
    .row_i  (row_q),
    .mask_i (mask_q),
    .del_i  (del_q),
    .fill_i (fill),
    .row_o  (row_step)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    mask_d  = mask_q;
    del_d   = del_q;
    k_d     = k_q;
    s_d     = s_q;
    carry_d = carry_q;
    cv_d    = cv_q;
`ifdef GROUP_SHIFT_MASK_CHECK_EN
    merr_d  = merr_q;
`endif
    case (state_q)
      IDLE: if (go) begin
        row_d   = rowIn;
        mask_d  = grpMask;
        del_d   = delOp;
        k_d     = inxBit ? 2'd2 : 2'd3;
        s_d     = 2'd0;
        carry_d = '0;
        cv_d    = 1'b0;
        state_d = (grpMask != '0) ? SHIFT : DONE;
`ifdef GROUP_SHIFT_MASK_CHECK_EN
        merr_d  = mask_holes(grpMask);
        if (mask_holes(grpMask)) state_d = DONE;
`endif
      end
      SHIFT: begin
        row_d = row_step;
        if (!del_q && mask_q[GROUP_CNT-1]) begin
          carry_d[slot*GROUP_BITS +: GROUP_BITS] = row_q[(GROUP_CNT-1)*GROUP_BITS +: GROUP_BITS];
          cv_d = 1'b1;
        end
        s_d = s_q + 2'd1;
        if (s_q == k_q - 2'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      mask_q  <= '0;
      del_q   <= 1'b0;
      k_q     <= 2'd0;
      s_q     <= 2'd0;
      carry_q <= '0;
      cv_q    <= 1'b0;
`ifdef GROUP_SHIFT_MASK_CHECK_EN
      merr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      del_q   <= del_d;
      k_q     <= k_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cv_q    <= cv_d;
`ifdef GROUP_SHIFT_MASK_CHECK_EN
      merr_q  <= merr_d;
`endif
    end
  end

  assign rowOut     = row_q;
  assign carryOut   = carry_q;
  assign carryValid = cv_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
`ifdef GROUP_SHIFT_MASK_CHECK_EN
  assign maskErr    = merr_q;
`else
  assign maskErr    = 1'b0;
`endif
endmodule

// File: tb/tb_group_shift.sv
// Bench for group_shift: directed cases plus random dense-mask ops against a net-placement model.
module tb_group_shift;
  logic         clk, reset, go, delOp, inxBit;
  logic [7:0]   grpMask;
  logic [511:0] rowIn, rowOut;
  logic [191:0] newItem, carryIn, carryOut;
  logic         carryValid, busy, done, maskErr;

  group_shift dut (
    .clk(clk), .reset(reset), .go(go), .delOp(delOp), .inxBit(inxBit),
    .grpMask(grpMask), .rowIn(rowIn), .newItem(newItem), .carryIn(carryIn),
    .rowOut(rowOut), .carryOut(carryOut), .carryValid(carryValid),
    .busy(busy), .done(done), .maskErr(maskErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [63:0]  r [8];
  logic [63:0]  it [3];
  logic [63:0]  ci [3];
  logic [511:0] erow;
  logic [191:0] ecar;
  logic         ecv;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Net placement: insert builds an extended row (row + carry slots); delete pulls from above.
  task automatic model(input logic dl, input int k, input int p);
    logic [63:0] ext [11];
    for (int i = 0; i < 11; i++) ext[i] = '0;
    erow = '0; ecar = '0; ecv = 1'b0;
    if (!dl) begin
      for (int g = 0; g < p; g++) ext[g] = r[g];
      for (int j = 0; j < k; j++) ext[p+j] = it[j];
      for (int g = p; g < 8; g++) ext[g+k] = r[g];
      for (int g = 0; g < 8; g++) erow[g*64 +: 64] = ext[g];
      if (p < 8) for (int i = 0; i < k; i++) ecar[i*64 +: 64] = ext[8+i];
      ecv = (p < 8);
    end else begin
      for (int g = 0; g < 8; g++)
        erow[g*64 +: 64] = (g < p) ? r[g] : ((g + k < 8) ? r[g+k] : ci[g+k-8]);
    end
  endtask

  task automatic drive_inputs(input logic dl, input logic inx, input logic [7:0] m);
    for (int g = 0; g < 8; g++) rowIn[g*64 +: 64] = r[g];
    for (int j = 0; j < 3; j++) begin
      newItem[j*64 +: 64] = it[j];
      carryIn[j*64 +: 64] = ci[j];
    end
    delOp = dl; inxBit = inx; grpMask = m;
  endtask

  // Called at #1 after an edge with the DUT idle; returns at #1 into the done cycle.
  task automatic run_op(input logic dl, input logic inx, input logic [7:0] m, input int exp_cyc);
    int cyc;
    drive_inputs(dl, inx, m);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 1;
    chk("busy_c1", busy, 1);
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_cycle", cyc, exp_cyc);
  endtask

  task automatic op_dense(input logic dl, input logic inx, input int p);
    logic [7:0] m;
    int k;
    m = 8'hFF << p;
    k = inx ? 2 : 3;
    run_op(dl, inx, m, (p == 8) ? 1 : k + 1);
    model(dl, k, p);
    chk("row", rowOut, erow);
    chk("carry", carryOut, ecar);
    chk("carry_valid", carryValid, ecv);
    chk("mask_err", maskErr, 0);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; delOp = 1'b0; inxBit = 1'b0; grpMask = '0;
    rowIn = '0; newItem = '0; carryIn = '0;
    #2;
    chk("rst_row", rowOut, 0);
    chk("rst_carry", carryOut, 0);
    chk("rst_flags", {carryValid, busy, done, maskErr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int g = 0; g < 8; g++) r[g] = 64'h10 + 64'(g);
    it[0] = 64'hA0; it[1] = 64'hA1; it[2] = 64'hA2;
    ci[0] = 64'hC0; ci[1] = 64'hC1; ci[2] = 64'hC2;

    // Insert hINDX at group 4
    op_dense(1'b0, 1'b1, 4);
    chk("ins_anchor", {rowOut[5*64 +: 64], rowOut[4*64 +: 64], carryOut[64 +: 64]},
        {64'hA1, 64'hA0, 64'h17});
    // Insert hPAGE, empty mask
    op_dense(1'b0, 1'b0, 8);
    // Delete hPAGE at group 3
    op_dense(1'b1, 1'b0, 3);
    chk("del_anchor", {rowOut[7*64 +: 64], rowOut[3*64 +: 64]}, {64'hC2, 64'h16});

    // Reset mid-shift
    drive_inputs(1'b0, 1'b0, 8'hF0);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_row", rowOut, 0);
    chk("mid_rst_carry", carryOut, 0);
    chk("mid_rst_flags", {carryValid, busy, done, maskErr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op_dense(1'b0, 1'b0, 5);

    // go held through busy: hINDX ops complete at cycles 3 and 7 only
    drive_inputs(1'b0, 1'b1, 8'hC0);
    go = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 5) go = 1'b0;
      chk($sformatf("held_go_done_c%0d", c), done, (c == 3 || c == 7));
    end
    @(posedge clk); #1;

    // Non-dense mask
`ifdef GROUP_SHIFT_MASK_CHECK_EN
    run_op(1'b0, 1'b1, 8'h0A, 1);
    chk("merr_flag", maskErr, 1);
    for (int g = 0; g < 8; g++) erow[g*64 +: 64] = r[g];
    chk("merr_row", rowOut, erow);
    @(posedge clk); #1;
    chk("merr_hold", maskErr, 1);
`else
    run_op(1'b0, 1'b1, 8'h0A, 3);
    chk("merr_tied", maskErr, 0);
    @(posedge clk); #1;
`endif

    // Random dense-mask ops
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < 8; g++) r[g] = {$urandom(), $urandom()};
      for (int j = 0; j < 3; j++) begin
        it[j] = {$urandom(), $urandom()};
        ci[j] = {$urandom(), $urandom()};
      end
      op_dense(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
